// File: rtl/irq_arbiter_if.sv
// Bus bundle between the soft-AVR core, the io peripherals and irq_arbiter.
// The master side is the core/peripheral set; the slave side is the arbiter.
interface irq_arbiter_if #(
  parameter int NSRC = 8
);
  logic [NSRC-1:0] src;
  logic [7:0]      SREG;
  logic [5:0]      IOCNT;
  logic [7:0]      IODIN;
  logic            IOW;
  logic            IOR;
  logic [7:0]      IODOUT;
  logic            irq_ack;
  logic            irq_reti;
  logic            IRQ_REQ;
  logic [3:0]      IRQ_ADD;
  logic            irq_active;

  modport master (
    output src, SREG, IOCNT, IODIN, IOW, IOR, irq_ack, irq_reti,
    input  IODOUT, IRQ_REQ, IRQ_ADD, irq_active
  );

  modport slave (
    input  src, SREG, IOCNT, IODIN, IOW, IOR, irq_ack, irq_reti,
    output IODOUT, IRQ_REQ, IRQ_ADD, irq_active
  );
endinterface

// File: rtl/irq_arbiter.sv
// Vectored interrupt arbiter: edge-latched pending flags, IO-mapped enable mask,
// fixed priority (bit 0 highest), one grant in flight until the core executes RETI.
module irq_arbiter #(
  parameter int         NSRC      = 8,
  parameter logic [5:0] ADDR_IMSK = 6'h3B,
  parameter logic [5:0] ADDR_IFLG = 6'h3A
) (
  input logic          clk,
  input logic          rst,
  irq_arbiter_if.slave bus
);

  localparam int              W   = (NSRC > 8) ? NSRC : 8;
  localparam logic [NSRC-1:0] ONE = NSRC'(1);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state;
  logic [NSRC-1:0] src_d;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] imsk;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] edge_set;
  logic [NSRC-1:0] w1c_clr;
  logic [NSRC-1:0] ack_clr;
  logic [W-1:0]    din_ext;
  logic [W-1:0]    pend_ext;
  logic [W-1:0]    imsk_ext;
  logic [3:0]      winner;
  logic            win_valid;
  logic [3:0]      gnt;
  logic            irq_req_q;
  logic [3:0]      irq_add_q;
  logic            irq_active_q;
  logic [7:0]      iodout;
  logic            wr_imsk;
  logic            wr_iflg;

  assign din_ext  = W'(bus.IODIN);
  assign pend_ext = W'(pending);
  assign imsk_ext = W'(imsk);
  assign wr_imsk  = bus.IOW && (bus.IOCNT == ADDR_IMSK);
  assign wr_iflg  = bus.IOW && (bus.IOCNT == ADDR_IFLG);
  assign edge_set = bus.src & ~src_d;
  assign w1c_clr  = wr_iflg ? din_ext[NSRC-1:0] : '0;
  assign ack_clr  = (state == REQ && bus.irq_ack) ? (ONE << gnt) : '0;
  assign elig     = pending & imsk;

  // Scanning downwards leaves the lowest eligible index as the winner.
  always_comb begin
    winner    = 4'd0;
    win_valid = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        winner    = 4'(i);
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    iodout = 8'h00;
    if (bus.IOR) begin
      if (bus.IOCNT == ADDR_IMSK)      iodout = imsk_ext[7:0];
      else if (bus.IOCNT == ADDR_IFLG) iodout = pend_ext[7:0];
    end
  end

  // A new edge in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_d   <= '0;
      pending <= '0;
      imsk    <= '0;
    end else begin
      src_d   <= bus.src;
      pending <= (pending & ~(w1c_clr | ack_clr)) | edge_set;
      if (wr_imsk) imsk <= din_ext[NSRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      gnt          <= 4'd0;
      irq_req_q    <= 1'b0;
      irq_add_q    <= 4'd0;
      irq_active_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid && bus.SREG[7]) begin
            gnt       <= winner;
            irq_add_q <= winner + 4'd1;
            irq_req_q <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus.irq_ack) begin
            irq_req_q    <= 1'b0;
            irq_active_q <= 1'b1;
            state        <= SERVICE;
          end else if (!bus.SREG[7]) begin
            irq_req_q <= 1'b0;
            state     <= IDLE;
          end
        end
        SERVICE: begin
          if (bus.irq_reti) begin
            irq_active_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          irq_req_q    <= 1'b0;
          irq_active_q <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign bus.IODOUT     = iodout;
  assign bus.IRQ_REQ    = irq_req_q;
  assign bus.IRQ_ADD    = irq_add_q;
  assign bus.irq_active = irq_active_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios followed by a random run scored
// against a behavioural model of pending flags, mask and grant phase.
module tb_irq_arbiter;
  localparam int NSRC = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  irq_arbiter_if #(.NSRC(NSRC)) bus();

  irq_arbiter #(.NSRC(NSRC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: phase 0 = waiting, 1 = requesting, 2 = handler running.
  bit m_pend[NSRC];
  bit m_prev[NSRC];
  bit m_imsk[NSRC];
  int m_phase;
  int m_vec;

  function automatic logic [7:0] pack(input bit b[NSRC]);
    int v = 0;
    for (int i = 0; i < NSRC; i++) if (b[i]) v += (1 << i);
    return 8'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) begin
      m_pend[i] = 0; m_prev[i] = 0; m_imsk[i] = 0;
    end
    m_phase = 0;
    m_vec   = 0;
  endtask

  task automatic model_step();
    int  win = -1;
    int  ack_idx = -1;
    bit  w1c = bus.IOW && (bus.IOCNT == 6'h3A);
    bit  wmk = bus.IOW && (bus.IOCNT == 6'h3B);
    for (int i = 0; i < NSRC; i++)
      if (win < 0 && m_pend[i] && m_imsk[i]) win = i;
    if (m_phase == 1 && bus.irq_ack) ack_idx = m_vec - 1;
    for (int i = 0; i < NSRC; i++) begin
      bit rise = bus.src[i] && !m_prev[i];
      bit clr  = (w1c && bus.IODIN[i]) || (i == ack_idx);
      if (rise) m_pend[i] = 1;
      else if (clr) m_pend[i] = 0;
      m_prev[i] = bus.src[i];
      if (wmk) m_imsk[i] = bus.IODIN[i];
    end
    if (m_phase == 0) begin
      if (win >= 0 && bus.SREG[7]) begin m_phase = 1; m_vec = win + 1; end
    end else if (m_phase == 1) begin
      if (bus.irq_ack) m_phase = 2;
      else if (!bus.SREG[7]) m_phase = 0;
    end else begin
      if (bus.irq_reti) m_phase = 0;
    end
  endtask

  task automatic tick();
    if (!rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.IOW = 0; bus.IOR = 0; bus.irq_ack = 0; bus.irq_reti = 0;
  endtask

  task automatic io_write(input logic [5:0] a, input logic [7:0] d);
    bus.IOW = 1; bus.IOCNT = a; bus.IODIN = d;
    tick();
    bus.IOW = 0;
  endtask

  task automatic io_read(input logic [5:0] a);
    bus.IOR = 1; bus.IOCNT = a;
    #1;
  endtask

  task automatic pulse_ack();
    bus.irq_ack = 1; tick(); bus.irq_ack = 0;
  endtask

  task automatic pulse_reti();
    bus.irq_reti = 1; tick(); bus.irq_reti = 0;
  endtask

  task automatic test_reset();
    rst = 0; bus.src = '0; bus.SREG = 8'h00; bus.IOCNT = 6'h00; bus.IODIN = 8'h00;
    quiet();
    tick(); tick();
    rst = 1;
    tick();
    checks++; if (bus.IRQ_REQ !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %0b want 0", bus.IRQ_REQ); end
    checks++; if (bus.IRQ_ADD !== 4'd0) begin errors++; $display("[TB] FAIL reset_add: got %0d want 0", bus.IRQ_ADD); end
    checks++; if (bus.irq_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %0b want 0", bus.irq_active); end
    io_read(6'h3A);
    checks++; if (bus.IODOUT !== 8'h00) begin errors++; $display("[TB] FAIL reset_iflg: got %h want 00", bus.IODOUT); end
    io_read(6'h3B);
    checks++; if (bus.IODOUT !== 8'h00) begin errors++; $display("[TB] FAIL reset_imsk: got %h want 00", bus.IODOUT); end
    bus.IOR = 0;
  endtask

  task automatic test_single();
    io_write(6'h3B, 8'h04);
    bus.SREG = 8'h80;
    bus.src = 8'h04;
    tick();
    checks++; if (bus.IRQ_REQ !== 1'b0) begin errors++; $display("[TB] FAIL single_latency1: got %0b want 0", bus.IRQ_REQ); end
    bus.src = 8'h00;
    tick();
    checks++; if (bus.IRQ_REQ !== 1'b1) begin errors++; $display("[TB] FAIL single_req: got %0b want 1", bus.IRQ_REQ); end
    checks++; if (bus.IRQ_ADD !== 4'd3) begin errors++; $display("[TB] FAIL single_add: got %0d want 3", bus.IRQ_ADD); end
    pulse_ack();
    checks++; if (bus.IRQ_REQ !== 1'b0) begin errors++; $display("[TB] FAIL single_req_after_ack: got %0b want 0", bus.IRQ_REQ); end
    checks++; if (bus.irq_active !== 1'b1) begin errors++; $display("[TB] FAIL single_active: got %0b want 1", bus.irq_active); end
    io_read(6'h3A);
    checks++; if (bus.IODOUT !== 8'h00) begin errors++; $display("[TB] FAIL single_iflg: got %h want 00", bus.IODOUT); end
    bus.IOR = 0;
    pulse_reti();
    checks++; if (bus.irq_active !== 1'b0) begin errors++; $display("[TB] FAIL single_reti: got %0b want 0", bus.irq_active); end
  endtask

  task automatic test_priority();
    io_write(6'h3B, 8'hFF);
    bus.src = 8'h22;
    tick();
    bus.src = 8'h00;
    tick();
    checks++; if (bus.IRQ_REQ !== 1'b1 || bus.IRQ_ADD !== 4'd2) begin errors++; $display("[TB] FAIL prio_first: got req=%0b add=%0d want req=1 add=2", bus.IRQ_REQ, bus.IRQ_ADD); end
    pulse_ack();
    pulse_reti();
    tick();
    checks++; if (bus.IRQ_REQ !== 1'b1 || bus.IRQ_ADD !== 4'd6) begin errors++; $display("[TB] FAIL prio_second: got req=%0b add=%0d want req=1 add=6", bus.IRQ_REQ, bus.IRQ_ADD); end
    pulse_ack();
    pulse_reti();
  endtask

  task automatic test_masking();
    io_write(6'h3B, 8'h00);
    bus.SREG = 8'h80;
    bus.src = 8'h08; tick();
    bus.src = 8'h00; tick(); tick();
    checks++; if (bus.IRQ_REQ !== 1'b0) begin errors++; $display("[TB] FAIL mask_noreq: got %0b want 0", bus.IRQ_REQ); end
    io_read(6'h3A);
    checks++; if (bus.IODOUT !== 8'h08) begin errors++; $display("[TB] FAIL mask_iflg: got %h want 08", bus.IODOUT); end
    bus.IOR = 0;
    bus.SREG = 8'h00;
    io_write(6'h3B, 8'h08);
    tick(); tick();
    checks++; if (bus.IRQ_REQ !== 1'b0) begin errors++; $display("[TB] FAIL iflag_noreq: got %0b want 0", bus.IRQ_REQ); end
    bus.SREG = 8'h80;
    tick();
    checks++; if (bus.IRQ_REQ !== 1'b1 || bus.IRQ_ADD !== 4'd4) begin errors++; $display("[TB] FAIL iflag_req: got req=%0b add=%0d want req=1 add=4", bus.IRQ_REQ, bus.IRQ_ADD); end
    bus.SREG = 8'h00;
    tick();
    checks++; if (bus.IRQ_REQ !== 1'b0) begin errors++; $display("[TB] FAIL withdraw: got %0b want 0", bus.IRQ_REQ); end
    io_read(6'h3A);
    checks++; if (bus.IODOUT !== 8'h08) begin errors++; $display("[TB] FAIL withdraw_iflg: got %h want 08", bus.IODOUT); end
    bus.IOR = 0;
  endtask

  task automatic test_w1c();
    io_write(6'h3A, 8'h08);
    io_read(6'h3A);
    checks++; if (bus.IODOUT !== 8'h00) begin errors++; $display("[TB] FAIL w1c_clear: got %h want 00", bus.IODOUT); end
    bus.IOR = 0;
    bus.src = 8'h08;
    io_write(6'h3A, 8'h08);
    bus.src = 8'h00;
    io_read(6'h3A);
    checks++; if (bus.IODOUT !== 8'h08) begin errors++; $display("[TB] FAIL set_wins: got %h want 08", bus.IODOUT); end
    bus.IOR = 0;
    io_write(6'h3A, 8'hFF);
    bus.src = 8'h08; tick();
    io_write(6'h3A, 8'h08);
    tick(); tick();
    io_read(6'h3A);
    checks++; if (bus.IODOUT !== 8'h00) begin errors++; $display("[TB] FAIL level_single_event: got %h want 00", bus.IODOUT); end
    bus.IOR = 0;
    bus.src = 8'h00;
    pulse_ack(); pulse_reti();
    checks++; if (bus.IRQ_REQ !== 1'b0 || bus.irq_active !== 1'b0) begin errors++; $display("[TB] FAIL stray_ack_reti: got req=%0b act=%0b want 0 0", bus.IRQ_REQ, bus.irq_active); end
  endtask

  task automatic test_async_reset();
    io_write(6'h3B, 8'h09);
    bus.SREG = 8'h80;
    bus.src = 8'h08; tick();
    bus.src = 8'h00; tick();
    pulse_ack();
    bus.src = 8'h01; tick();
    bus.src = 8'h00; tick();
    checks++; if (bus.irq_active !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_active: got %0b want 1", bus.irq_active); end
    #2;
    rst = 0;
    #1;
    model_reset();
    checks++; if (bus.IRQ_REQ !== 1'b0 || bus.irq_active !== 1'b0) begin errors++; $display("[TB] FAIL async_outputs: got req=%0b act=%0b want 0 0", bus.IRQ_REQ, bus.irq_active); end
    io_read(6'h3A);
    checks++; if (bus.IODOUT !== 8'h00) begin errors++; $display("[TB] FAIL async_pending: got %h want 00", bus.IODOUT); end
    bus.IOR = 0;
    #1;
    rst = 1;
    @(posedge clk); #1;
    io_write(6'h3B, 8'hFF);
    tick(); tick(); tick();
    checks++; if (bus.IRQ_REQ !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_quiet: got %0b want 0", bus.IRQ_REQ); end
    bus.src = 8'h01; tick();
    bus.src = 8'h00; tick();
    checks++; if (bus.IRQ_REQ !== 1'b1 || bus.IRQ_ADD !== 4'd1) begin errors++; $display("[TB] FAIL post_reset_edge: got req=%0b add=%0d want req=1 add=1", bus.IRQ_REQ, bus.IRQ_ADD); end
    pulse_ack(); pulse_reti();
  endtask

  task automatic test_random();
    logic [7:0] exp_dout;
    for (int n = 0; n < 600; n++) begin
      bus.src      = 8'($urandom) & 8'($urandom);
      bus.SREG     = ($urandom_range(0, 3) != 0) ? 8'h80 : 8'h00;
      bus.IOW      = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 2))
        0: bus.IOCNT = 6'h3A;
        1: bus.IOCNT = 6'h3B;
        default: bus.IOCNT = 6'($urandom);
      endcase
      bus.IODIN    = 8'($urandom);
      bus.IOR      = $urandom_range(0, 1) == 1;
      bus.irq_ack  = ($urandom_range(0, 2) == 0);
      bus.irq_reti = ($urandom_range(0, 3) == 0);
      #1;
      exp_dout = 8'h00;
      if (bus.IOR && bus.IOCNT == 6'h3B) exp_dout = pack(m_imsk);
      else if (bus.IOR && bus.IOCNT == 6'h3A) exp_dout = pack(m_pend);
      checks++; if (bus.IODOUT !== exp_dout) begin errors++; $display("[TB] FAIL rnd_dout[%0d]: got %h want %h", n, bus.IODOUT, exp_dout); end
      tick();
      checks++; if (bus.IRQ_REQ !== (m_phase == 1)) begin errors++; $display("[TB] FAIL rnd_req[%0d]: got %0b want %0b", n, bus.IRQ_REQ, m_phase == 1); end
      checks++; if (bus.irq_active !== (m_phase == 2)) begin errors++; $display("[TB] FAIL rnd_active[%0d]: got %0b want %0b", n, bus.irq_active, m_phase == 2); end
      checks++; if (bus.IRQ_ADD !== 4'(m_vec)) begin errors++; $display("[TB] FAIL rnd_add[%0d]: got %0d want %0d", n, bus.IRQ_ADD, m_vec); end
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_w1c();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
